fwd_hazard_ctrl: RTL and testbench

- Parametrised successor to the pipeline's combinational forwarding unit.
- Evaluates RAW hazards for the instruction in ID against producers in EX and MEM, and registers the forwarding selects into the ID/EX boundary, so EX sees stable selects from cycle start.
- Generates load-use stalls for a configurable load latency, branch flushes and global memory-busy freeze.
- Keeps saturating performance counters for stall and flush cycles.

---
 rtl/fwd_hazard_ctrl.sv | 134 +++++++++++++
 tb/tb_fwd_hazard_ctrl.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_ctrl.sv
// rtl/fwd_hazard_ctrl.sv - registered operand forwarding, load-use stall, branch flush and freeze control
module fwd_hazard_ctrl #(
    parameter int RAW      = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [RAW-1:0]   id_rR1,
    input  logic [RAW-1:0]   id_rR2,
    input  logic             id_r1_used,
    input  logic             id_r2_used,
    input  logic             id_st_used,
    input  logic [RAW-1:0]   ex_wR,
    input  logic [RAW-1:0]   mem_wR,
    input  logic             ex_rf_we,
    input  logic             mem_rf_we,
    input  logic             ex_is_load,
    input  logic             mem_is_load,
    input  logic             br_taken,
    input  logic             mem_busy,
    output logic [1:0]       ex_fwd_a_sel,
    output logic [1:0]       ex_fwd_b_sel,
    output logic [1:0]       ex_fwd_st_sel,
    output logic             pc_stall,
    output logic             if_id_stall,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_cycles
);

    localparam logic [1:0]       SEL_RF  = 2'b00;
    localparam logic [1:0]       SEL_EX  = 2'b01;
    localparam logic [1:0]       SEL_MEM = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic ex_hit1, ex_hit2, mem_hit1, mem_hit2;
    logic ex_m1, ex_m2, mem_m1, mem_m2;
    logic load_use;
    logic [1:0] nxt_a, nxt_b, nxt_st;

    logic [1:0]       sel_a_q, sel_a_d;
    logic [1:0]       sel_b_q, sel_b_d;
    logic [1:0]       sel_st_q, sel_st_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    // Producer hits ignore the consumer's use flags; x0 is never a producer.
    always_comb begin
        ex_hit1  = ex_rf_we  && (ex_wR  != '0) && (ex_wR  == id_rR1);
        ex_hit2  = ex_rf_we  && (ex_wR  != '0) && (ex_wR  == id_rR2);
        mem_hit1 = mem_rf_we && (mem_wR != '0) && (mem_wR == id_rR1);
        mem_hit2 = mem_rf_we && (mem_wR != '0) && (mem_wR == id_rR2);

        ex_m1  = id_r1_used && ex_hit1;
        ex_m2  = (id_r2_used || id_st_used) && ex_hit2;
        mem_m1 = id_r1_used && mem_hit1;
        mem_m2 = (id_r2_used || id_st_used) && mem_hit2;

        load_use = (ex_is_load && (ex_m1 || ex_m2))
                || ((LOAD_LAT == 2) && mem_is_load && (mem_m1 || mem_m2));

        nxt_a  = ex_m1 ? SEL_EX : (mem_m1 ? SEL_MEM : SEL_RF);
        nxt_b  = (id_r2_used && ex_hit2)  ? SEL_EX
               : (id_r2_used && mem_hit2) ? SEL_MEM : SEL_RF;
        nxt_st = (id_st_used && ex_hit2)  ? SEL_EX
               : (id_st_used && mem_hit2) ? SEL_MEM : SEL_RF;
    end

    always_comb begin
        pc_stall    = 1'b0;
        if_id_stall = 1'b0;
        if_id_flush = 1'b0;
        id_ex_flush = 1'b0;
        if (mem_busy) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
        end else if (br_taken) begin
            // The ID instruction is killed, so any load-use on it is moot.
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
        end else if (load_use) begin
            pc_stall    = 1'b1;
            if_id_stall = 1'b1;
            id_ex_flush = 1'b1;
        end
    end

    always_comb begin
        sel_a_d  = nxt_a;
        sel_b_d  = nxt_b;
        sel_st_d = nxt_st;
        if (mem_busy) begin
            sel_a_d  = sel_a_q;
            sel_b_d  = sel_b_q;
            sel_st_d = sel_st_q;
        end else if (id_ex_flush) begin
            sel_a_d  = SEL_RF;
            sel_b_d  = SEL_RF;
            sel_st_d = SEL_RF;
        end

        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (pc_stall && (stall_cnt_q != CNT_MAX))
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        if (if_id_flush && (flush_cnt_q != CNT_MAX))
            flush_cnt_d = flush_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sel_a_q     <= SEL_RF;
            sel_b_q     <= SEL_RF;
            sel_st_q    <= SEL_RF;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            sel_a_q     <= sel_a_d;
            sel_b_q     <= sel_b_d;
            sel_st_q    <= sel_st_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign ex_fwd_a_sel  = sel_a_q;
    assign ex_fwd_b_sel  = sel_b_q;
    assign ex_fwd_st_sel = sel_st_q;
    assign stall_cycles  = stall_cnt_q;
    assign flush_cycles  = flush_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// tb/tb_fwd_hazard_ctrl.sv - directed bench over LOAD_LAT=1, LOAD_LAT=2 and CNT_W=4 instances
module tb_fwd_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rR1, id_rR2, ex_wR, mem_wR;
    logic       id_r1_used, id_r2_used, id_st_used;
    logic       ex_rf_we, mem_rf_we, ex_is_load, mem_is_load;
    logic       br_taken, mem_busy;

    logic [1:0]  a1, b1, st1, a2, b2, st2, as, bs, sts;
    logic        pcs1, ifs1, iff1, idf1;
    logic        pcs2, ifs2, iff2, idf2;
    logic        pcss, ifss, iffs, idfs;
    logic [15:0] sc1, fc1, sc2, fc2;
    logic [3:0]  scs, fcs;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    fwd_hazard_ctrl #(.RAW(5), .LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst(rst), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_st_used(id_st_used),
        .ex_wR(ex_wR), .mem_wR(mem_wR), .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .ex_fwd_a_sel(a1), .ex_fwd_b_sel(b1), .ex_fwd_st_sel(st1),
        .pc_stall(pcs1), .if_id_stall(ifs1), .if_id_flush(iff1), .id_ex_flush(idf1),
        .stall_cycles(sc1), .flush_cycles(fc1)
    );

    fwd_hazard_ctrl #(.RAW(5), .LOAD_LAT(2), .CNT_W(16)) dut2 (
        .clk(clk), .rst(rst), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_st_used(id_st_used),
        .ex_wR(ex_wR), .mem_wR(mem_wR), .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .ex_fwd_a_sel(a2), .ex_fwd_b_sel(b2), .ex_fwd_st_sel(st2),
        .pc_stall(pcs2), .if_id_stall(ifs2), .if_id_flush(iff2), .id_ex_flush(idf2),
        .stall_cycles(sc2), .flush_cycles(fc2)
    );

    fwd_hazard_ctrl #(.RAW(5), .LOAD_LAT(1), .CNT_W(4)) dut_s (
        .clk(clk), .rst(rst), .id_rR1(id_rR1), .id_rR2(id_rR2),
        .id_r1_used(id_r1_used), .id_r2_used(id_r2_used), .id_st_used(id_st_used),
        .ex_wR(ex_wR), .mem_wR(mem_wR), .ex_rf_we(ex_rf_we), .mem_rf_we(mem_rf_we),
        .ex_is_load(ex_is_load), .mem_is_load(mem_is_load), .br_taken(br_taken),
        .mem_busy(mem_busy), .ex_fwd_a_sel(as), .ex_fwd_b_sel(bs), .ex_fwd_st_sel(sts),
        .pc_stall(pcss), .if_id_stall(ifss), .if_id_flush(iffs), .id_ex_flush(idfs),
        .stall_cycles(scs), .flush_cycles(fcs)
    );

    task automatic idle();
        id_rR1 = 5'd0; id_rR2 = 5'd0;
        id_r1_used = 1'b0; id_r2_used = 1'b0; id_st_used = 1'b0;
        ex_wR = 5'd0; mem_wR = 5'd0;
        ex_rf_we = 1'b0; mem_rf_we = 1'b0;
        ex_is_load = 1'b0; mem_is_load = 1'b0;
        br_taken = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        idle();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        #2;
        tests++;
        if ({a1, b1, st1} !== 6'b0) begin
            fails++; $display("FAIL reset_sel: got %b want 000000", {a1, b1, st1});
        end
        tests++;
        if (sc1 !== 16'd0 || fc1 !== 16'd0) begin
            fails++; $display("FAIL reset_cnt: got %0d/%0d want 0/0", sc1, fc1);
        end
        tests++;
        if ({pcs1, ifs1, iff1, idf1} !== 4'b0) begin
            fails++; $display("FAIL reset_ctrl: got %b want 0000", {pcs1, ifs1, iff1, idf1});
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_fwd_priority();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd5; ex_rf_we = 1'b1; mem_wR = 5'd5; mem_rf_we = 1'b1;
        id_rR1 = 5'd5; id_rR2 = 5'd5; id_r1_used = 1'b1; id_r2_used = 1'b1;
        #1;
        tests++;
        if ({pcs1, idf1} !== 2'b00) begin
            fails++; $display("FAIL fwd_nostall: got %b want 00", {pcs1, idf1});
        end
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b01 || b1 !== 2'b01 || st1 !== 2'b00) begin
            fails++; $display("FAIL fwd_ex_prio: got a=%b b=%b st=%b want 01 01 00", a1, b1, st1);
        end
        @(negedge clk);
        ex_wR = 5'd7;
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b10 || b1 !== 2'b10) begin
            fails++; $display("FAIL fwd_mem: got a=%b b=%b want 10 10", a1, b1);
        end
        @(negedge clk);
        ex_wR = 5'd5; id_r1_used = 1'b0; id_r2_used = 1'b0; id_st_used = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b00 || b1 !== 2'b00 || st1 !== 2'b01) begin
            fails++; $display("FAIL fwd_store: got a=%b b=%b st=%b want 00 00 01", a1, b1, st1);
        end
    endtask

    task automatic test_load_use_lat1();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd3; ex_rf_we = 1'b1; ex_is_load = 1'b1;
        id_rR1 = 5'd3; id_r1_used = 1'b1;
        #1;
        tests++;
        if ({pcs1, ifs1, iff1, idf1} !== 4'b1101) begin
            fails++; $display("FAIL lu1_ctrl: got %b want 1101", {pcs1, ifs1, iff1, idf1});
        end
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b00 || sc1 !== 16'd1) begin
            fails++; $display("FAIL lu1_bubble: got a=%b stall=%0d want 00 1", a1, sc1);
        end
        @(negedge clk);
        ex_wR = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0;
        mem_wR = 5'd3; mem_rf_we = 1'b1; mem_is_load = 1'b1;
        #1;
        tests++;
        if ({pcs1, idf1} !== 2'b00) begin
            fails++; $display("FAIL lu1_release: got %b want 00", {pcs1, idf1});
        end
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b10 || sc1 !== 16'd1) begin
            fails++; $display("FAIL lu1_fwd: got a=%b stall=%0d want 10 1", a1, sc1);
        end
    endtask

    task automatic test_load_use_lat2();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd3; ex_rf_we = 1'b1; ex_is_load = 1'b1;
        id_rR1 = 5'd3; id_r1_used = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ex_wR = 5'd0; ex_rf_we = 1'b0; ex_is_load = 1'b0;
        mem_wR = 5'd3; mem_rf_we = 1'b1; mem_is_load = 1'b1;
        #1;
        tests++;
        if ({pcs2, ifs2, iff2, idf2} !== 4'b1101) begin
            fails++; $display("FAIL lu2_second: got %b want 1101", {pcs2, ifs2, iff2, idf2});
        end
        @(posedge clk); #1;
        tests++;
        if (a2 !== 2'b00 || sc2 !== 16'd2) begin
            fails++; $display("FAIL lu2_cnt: got a=%b stall=%0d want 00 2", a2, sc2);
        end
        @(negedge clk);
        mem_wR = 5'd0; mem_rf_we = 1'b0; mem_is_load = 1'b0;
        #1;
        tests++;
        if (pcs2 !== 1'b0) begin
            fails++; $display("FAIL lu2_release: got %b want 0", pcs2);
        end
        @(posedge clk); #1;
        tests++;
        if (a2 !== 2'b00 || sc2 !== 16'd2) begin
            fails++; $display("FAIL lu2_final: got a=%b stall=%0d want 00 2", a2, sc2);
        end
    endtask

    task automatic test_lat2_gap();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd9; ex_rf_we = 1'b1;
        mem_wR = 5'd3; mem_rf_we = 1'b1; mem_is_load = 1'b1;
        id_rR2 = 5'd3; id_r2_used = 1'b1;
        #1;
        tests++;
        if (pcs1 !== 1'b0 || pcs2 !== 1'b1 || idf2 !== 1'b1) begin
            fails++; $display("FAIL gap_ctrl: got lat1=%b lat2=%b%b want 0 11", pcs1, pcs2, idf2);
        end
        @(posedge clk); #1;
        tests++;
        if (b1 !== 2'b10 || b2 !== 2'b00 || sc2 !== 16'd1) begin
            fails++; $display("FAIL gap_sel: got b1=%b b2=%b stall2=%0d want 10 00 1", b1, b2, sc2);
        end
    endtask

    task automatic test_branch_vs_lu();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd3; ex_rf_we = 1'b1; id_rR1 = 5'd3; id_r1_used = 1'b1;
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b01) begin
            fails++; $display("FAIL br_pre: got %b want 01", a1);
        end
        @(negedge clk);
        ex_is_load = 1'b1; br_taken = 1'b1;
        #1;
        tests++;
        if ({pcs1, ifs1, iff1, idf1} !== 4'b0011) begin
            fails++; $display("FAIL br_ctrl: got %b want 0011", {pcs1, ifs1, iff1, idf1});
        end
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b00 || fc1 !== 16'd1 || sc1 !== 16'd0) begin
            fails++; $display("FAIL br_post: got a=%b flush=%0d stall=%0d want 00 1 0", a1, fc1, sc1);
        end
    endtask

    task automatic test_freeze_x0();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd5; ex_rf_we = 1'b1; id_rR1 = 5'd5; id_r1_used = 1'b1;
        @(posedge clk);
        @(negedge clk);
        idle();
        mem_busy = 1'b1;
        #1;
        tests++;
        if ({pcs1, ifs1, iff1, idf1} !== 4'b1100) begin
            fails++; $display("FAIL frz_ctrl: got %b want 1100", {pcs1, ifs1, iff1, idf1});
        end
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            tests++;
            if (a1 !== 2'b01) begin
                fails++; $display("FAIL frz_hold%0d: got %b want 01", i, a1);
            end
        end
        tests++;
        if (sc1 !== 16'd3) begin
            fails++; $display("FAIL frz_cnt: got %0d want 3", sc1);
        end
        @(negedge clk);
        idle();
        ex_wR = 5'd0; ex_rf_we = 1'b1; ex_is_load = 1'b1; id_rR1 = 5'd0; id_r1_used = 1'b1;
        #1;
        tests++;
        if (pcs1 !== 1'b0 || idf1 !== 1'b0) begin
            fails++; $display("FAIL x0_ctrl: got %b%b want 00", pcs1, idf1);
        end
        @(posedge clk); #1;
        tests++;
        if (a1 !== 2'b00 || sc1 !== 16'd3) begin
            fails++; $display("FAIL x0_sel: got a=%b stall=%0d want 00 3", a1, sc1);
        end
    endtask

    task automatic test_saturation_reset();
        do_reset();
        @(negedge clk);
        ex_wR = 5'd5; ex_rf_we = 1'b1; id_rR1 = 5'd5; id_r1_used = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_busy = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        tests++;
        if (scs !== 4'd15 || as !== 2'b01) begin
            fails++; $display("FAIL sat_cnt: got stall=%0d a=%b want 15 01", scs, as);
        end
        tests++;
        if (sc1 !== 16'd20) begin
            fails++; $display("FAIL sat_wide: got %0d want 20", sc1);
        end
        @(negedge clk);
        #1;
        rst = 1'b1;
        #1;
        tests++;
        if (scs !== 4'd0 || as !== 2'b00 || sc1 !== 16'd0 || a1 !== 2'b00) begin
            fails++; $display("FAIL async_rst: got s=%0d as=%b sc1=%0d a1=%b want 0 00 0 00", scs, as, sc1, a1);
        end
        tests++;
        if (pcss !== 1'b1) begin
            fails++; $display("FAIL rst_comb: got %b want 1", pcss);
        end
        @(negedge clk);
        idle();
        rst = 1'b0;
    endtask

    initial begin
        test_reset();
        test_fwd_priority();
        test_load_use_lat1();
        test_load_use_lat2();
        test_lat2_gap();
        test_branch_vs_lu();
        test_freeze_x0();
        test_saturation_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
